// File: rtl/issue_slot_queue.sv
// issue_slot_queue: age-ordered, collapsing integer issue queue.
// Holds renamed uops until both source operands are ready, then issues the
// oldest ready entry through a one-cycle output register.
// Optional feature: define ISSUE_QUEUE_COUNT_EN to add the io_count output.
module issue_slot_queue #(
    parameter int NUM_ENTRIES  = 4,
    parameter int WAKEUP_PORTS = 2,
    parameter int PAYLOAD_W    = 64
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      io_enq_valid,
    output logic                      io_enq_ready,
    input  logic [6:0]                io_enq_uop_uopc,
    input  logic [6:0]                io_enq_uop_prs1,
    input  logic [6:0]                io_enq_uop_prs2,
    input  logic [1:0]                io_enq_uop_lrs1_rtype,
    input  logic [1:0]                io_enq_uop_lrs2_rtype,
    input  logic                      io_enq_prs1_busy,
    input  logic                      io_enq_prs2_busy,
    input  logic [15:0]               io_enq_uop_br_mask,
    input  logic [PAYLOAD_W-1:0]      io_enq_uop_payload,
    input  logic [WAKEUP_PORTS-1:0]   io_wakeup_valid,
    input  logic [7*WAKEUP_PORTS-1:0] io_wakeup_pdst,
    input  logic [15:0]               io_br_resolve_mask,
    input  logic [15:0]               io_br_mispredict_mask,
    input  logic                      io_flush,
    output logic                      io_iss_valid,
    output logic [6:0]                io_iss_uop_uopc,
    output logic [6:0]                io_iss_uop_prs1,
    output logic [6:0]                io_iss_uop_prs2,
    output logic [1:0]                io_iss_uop_lrs1_rtype,
    output logic [1:0]                io_iss_uop_lrs2_rtype,
    output logic [15:0]               io_iss_uop_br_mask,
    output logic [PAYLOAD_W-1:0]      io_iss_uop_payload
`ifdef ISSUE_QUEUE_COUNT_EN
    ,
    output logic [3:0]                io_count
`endif
);

    localparam int CW = 4;

    // Entry storage (index 0 is oldest)
    logic [NUM_ENTRIES-1:0] val_q, val_d;
    logic [NUM_ENTRIES-1:0] p1_q, p1_d;
    logic [NUM_ENTRIES-1:0] p2_q, p2_d;
    logic [6:0]             uopc_q [NUM_ENTRIES];
    logic [6:0]             uopc_d [NUM_ENTRIES];
    logic [6:0]             prs1_q [NUM_ENTRIES];
    logic [6:0]             prs1_d [NUM_ENTRIES];
    logic [6:0]             prs2_q [NUM_ENTRIES];
    logic [6:0]             prs2_d [NUM_ENTRIES];
    logic [1:0]             rt1_q  [NUM_ENTRIES];
    logic [1:0]             rt1_d  [NUM_ENTRIES];
    logic [1:0]             rt2_q  [NUM_ENTRIES];
    logic [1:0]             rt2_d  [NUM_ENTRIES];
    logic [15:0]            brm_q  [NUM_ENTRIES];
    logic [15:0]            brm_d  [NUM_ENTRIES];
    logic [PAYLOAD_W-1:0]   pay_q  [NUM_ENTRIES];
    logic [PAYLOAD_W-1:0]   pay_d  [NUM_ENTRIES];

    // Output register
    logic                 ov_q, ov_d;
    logic [6:0]           o_uopc_q, o_uopc_d;
    logic [6:0]           o_prs1_q, o_prs1_d;
    logic [6:0]           o_prs2_q, o_prs2_d;
    logic [1:0]           o_rt1_q, o_rt1_d;
    logic [1:0]           o_rt2_q, o_rt2_d;
    logic [15:0]          o_brm_q, o_brm_d;
    logic [PAYLOAD_W-1:0] o_pay_q, o_pay_d;

    // Per-entry status
    logic [NUM_ENTRIES-1:0] kill, elig, wk1, wk2, sel_oh, surv;
    logic                   sel_any;
    logic [CW-1:0]          pos [NUM_ENTRIES];
    logic [CW-1:0]          surv_cnt;
    logic [CW-1:0]          occ_cnt;

    // Enqueue-side signals
    logic enq_fire, enq_kill, enq_wr, enq_p1, enq_p2;

    function automatic logic wake_hit(
        input logic [6:0]                preg,
        input logic [WAKEUP_PORTS-1:0]   wv,
        input logic [7*WAKEUP_PORTS-1:0] wp
    );
        logic hit;
        hit = 1'b0;
        for (int unsigned k = 0; k < WAKEUP_PORTS; k++) begin
            if (wv[k] && (wp[7*k +: 7] == preg)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Kill, eligibility and wakeup hits for each stored entry
    always_comb begin
        kill = '0;
        elig = '0;
        wk1  = '0;
        wk2  = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            kill[i] = val_q[i] & (|(brm_q[i] & io_br_mispredict_mask));
            elig[i] = val_q[i] & p1_q[i] & p2_q[i] & ~kill[i];
            wk1[i]  = (rt1_q[i] == 2'h0) & wake_hit(prs1_q[i], io_wakeup_valid, io_wakeup_pdst);
            wk2[i]  = (rt2_q[i] == 2'h0) & wake_hit(prs2_q[i], io_wakeup_valid, io_wakeup_pdst);
        end
    end

    // Oldest-first select among eligible entries
    always_comb begin
        sel_oh  = '0;
        sel_any = 1'b0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (elig[i] && !sel_any) begin
                sel_oh[i] = 1'b1;
                sel_any   = 1'b1;
            end
        end
    end

    // Survivors, their compacted positions, and current occupancy
    always_comb begin
        surv     = val_q & ~kill & ~sel_oh & {NUM_ENTRIES{~io_flush}};
        surv_cnt = '0;
        occ_cnt  = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            pos[i]   = surv_cnt;
            surv_cnt = surv_cnt + CW'(surv[i]);
            occ_cnt  = occ_cnt + CW'(val_q[i]);
        end
    end

    // Enqueue handshake and operand readiness of the incoming uop
    always_comb begin
        io_enq_ready = (occ_cnt < CW'(NUM_ENTRIES));
        enq_fire     = io_enq_valid & io_enq_ready;
        enq_kill     = |(io_enq_uop_br_mask & io_br_mispredict_mask);
        enq_wr       = enq_fire & ~enq_kill & ~io_flush;
        enq_p1       = (io_enq_uop_lrs1_rtype != 2'h0) | ~io_enq_prs1_busy |
                       wake_hit(io_enq_uop_prs1, io_wakeup_valid, io_wakeup_pdst);
        enq_p2       = (io_enq_uop_lrs2_rtype != 2'h0) | ~io_enq_prs2_busy |
                       wake_hit(io_enq_uop_prs2, io_wakeup_valid, io_wakeup_pdst);
    end

    // Next entry state: survivors slide down to their compacted slot with
    // wakeup/resolve applied; a new uop lands just above the last survivor
    always_comb begin
        val_d  = '0;
        p1_d   = p1_q;
        p2_d   = p2_q;
        uopc_d = uopc_q;
        prs1_d = prs1_q;
        prs2_d = prs2_q;
        rt1_d  = rt1_q;
        rt2_d  = rt2_q;
        brm_d  = brm_q;
        pay_d  = pay_q;
        for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                if (surv[i] && (pos[i] == CW'(k))) begin
                    val_d[k]  = 1'b1;
                    p1_d[k]   = p1_q[i] | wk1[i];
                    p2_d[k]   = p2_q[i] | wk2[i];
                    uopc_d[k] = uopc_q[i];
                    prs1_d[k] = prs1_q[i];
                    prs2_d[k] = prs2_q[i];
                    rt1_d[k]  = rt1_q[i];
                    rt2_d[k]  = rt2_q[i];
                    brm_d[k]  = brm_q[i] & ~io_br_resolve_mask;
                    pay_d[k]  = pay_q[i];
                end
            end
            if (enq_wr && (surv_cnt == CW'(k))) begin
                val_d[k]  = 1'b1;
                p1_d[k]   = enq_p1;
                p2_d[k]   = enq_p2;
                uopc_d[k] = io_enq_uop_uopc;
                prs1_d[k] = io_enq_uop_prs1;
                prs2_d[k] = io_enq_uop_prs2;
                rt1_d[k]  = io_enq_uop_lrs1_rtype;
                rt2_d[k]  = io_enq_uop_lrs2_rtype;
                brm_d[k]  = io_enq_uop_br_mask & ~io_br_resolve_mask;
                pay_d[k]  = io_enq_uop_payload;
            end
        end
    end

    // Next output register: load the selected entry, else hold fields
    always_comb begin
        ov_d     = sel_any & ~io_flush;
        o_uopc_d = o_uopc_q;
        o_prs1_d = o_prs1_q;
        o_prs2_d = o_prs2_q;
        o_rt1_d  = o_rt1_q;
        o_rt2_d  = o_rt2_q;
        o_brm_d  = o_brm_q & ~io_br_resolve_mask;
        o_pay_d  = o_pay_q;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (sel_oh[i]) begin
                o_uopc_d = uopc_q[i];
                o_prs1_d = prs1_q[i];
                o_prs2_d = prs2_q[i];
                o_rt1_d  = rt1_q[i];
                o_rt2_d  = rt2_q[i];
                o_brm_d  = brm_q[i] & ~io_br_resolve_mask;
                o_pay_d  = pay_q[i];
            end
        end
    end

    // Valid bits and output register, cleared asynchronously
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            val_q    <= '0;
            ov_q     <= 1'b0;
            o_uopc_q <= '0;
            o_prs1_q <= '0;
            o_prs2_q <= '0;
            o_rt1_q  <= '0;
            o_rt2_q  <= '0;
            o_brm_q  <= '0;
            o_pay_q  <= '0;
        end else begin
            val_q    <= val_d;
            ov_q     <= ov_d;
            o_uopc_q <= o_uopc_d;
            o_prs1_q <= o_prs1_d;
            o_prs2_q <= o_prs2_d;
            o_rt1_q  <= o_rt1_d;
            o_rt2_q  <= o_rt2_d;
            o_brm_q  <= o_brm_d;
            o_pay_q  <= o_pay_d;
        end
    end

    // Entry contents; only meaningful while the matching valid bit is set
    always_ff @(posedge clock) begin
        p1_q   <= p1_d;
        p2_q   <= p2_d;
        uopc_q <= uopc_d;
        prs1_q <= prs1_d;
        prs2_q <= prs2_d;
        rt1_q  <= rt1_d;
        rt2_q  <= rt2_d;
        brm_q  <= brm_d;
        pay_q  <= pay_d;
    end

`ifdef ISSUE_QUEUE_COUNT_EN
    logic [CW-1:0] count_q;

    // Registered occupancy after this cycle's removals and enqueue
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= surv_cnt + CW'(enq_wr);
        end
    end

    assign io_count = count_q;
`endif

    // A held uop is suppressed the same cycle it is killed or flushed
    assign io_iss_valid          = ov_q & ~(|(o_brm_q & io_br_mispredict_mask)) & ~io_flush;
    assign io_iss_uop_uopc       = o_uopc_q;
    assign io_iss_uop_prs1       = o_prs1_q;
    assign io_iss_uop_prs2       = o_prs2_q;
    assign io_iss_uop_lrs1_rtype = o_rt1_q;
    assign io_iss_uop_lrs2_rtype = o_rt2_q;
    assign io_iss_uop_br_mask    = o_brm_q;
    assign io_iss_uop_payload    = o_pay_q;

endmodule

// File: tb/tb_issue_slot_queue.sv
// Testbench for issue_slot_queue: directed scenarios plus random traffic,
// checked against a list-based reference model through a scoreboard.
module tb_issue_slot_queue;

    localparam int N  = 4;
    localparam int WP = 2;
    localparam int PW = 64;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          io_enq_valid;
    logic          io_enq_ready;
    logic [6:0]    io_enq_uop_uopc, io_enq_uop_prs1, io_enq_uop_prs2;
    logic [1:0]    io_enq_uop_lrs1_rtype, io_enq_uop_lrs2_rtype;
    logic          io_enq_prs1_busy, io_enq_prs2_busy;
    logic [15:0]   io_enq_uop_br_mask;
    logic [PW-1:0] io_enq_uop_payload;
    logic [WP-1:0] io_wakeup_valid;
    logic [7*WP-1:0] io_wakeup_pdst;
    logic [15:0]   io_br_resolve_mask, io_br_mispredict_mask;
    logic          io_flush;
    logic          io_iss_valid;
    logic [6:0]    io_iss_uop_uopc, io_iss_uop_prs1, io_iss_uop_prs2;
    logic [1:0]    io_iss_uop_lrs1_rtype, io_iss_uop_lrs2_rtype;
    logic [15:0]   io_iss_uop_br_mask;
    logic [PW-1:0] io_iss_uop_payload;
`ifdef ISSUE_QUEUE_COUNT_EN
    logic [3:0]    io_count;
`endif

    always #5 clock = ~clock;

    issue_slot_queue #(.NUM_ENTRIES(N), .WAKEUP_PORTS(WP), .PAYLOAD_W(PW)) dut (
        .clock(clock), .reset_n(reset_n),
        .io_enq_valid(io_enq_valid), .io_enq_ready(io_enq_ready),
        .io_enq_uop_uopc(io_enq_uop_uopc), .io_enq_uop_prs1(io_enq_uop_prs1),
        .io_enq_uop_prs2(io_enq_uop_prs2),
        .io_enq_uop_lrs1_rtype(io_enq_uop_lrs1_rtype), .io_enq_uop_lrs2_rtype(io_enq_uop_lrs2_rtype),
        .io_enq_prs1_busy(io_enq_prs1_busy), .io_enq_prs2_busy(io_enq_prs2_busy),
        .io_enq_uop_br_mask(io_enq_uop_br_mask), .io_enq_uop_payload(io_enq_uop_payload),
        .io_wakeup_valid(io_wakeup_valid), .io_wakeup_pdst(io_wakeup_pdst),
        .io_br_resolve_mask(io_br_resolve_mask), .io_br_mispredict_mask(io_br_mispredict_mask),
        .io_flush(io_flush),
        .io_iss_valid(io_iss_valid), .io_iss_uop_uopc(io_iss_uop_uopc),
        .io_iss_uop_prs1(io_iss_uop_prs1), .io_iss_uop_prs2(io_iss_uop_prs2),
        .io_iss_uop_lrs1_rtype(io_iss_uop_lrs1_rtype), .io_iss_uop_lrs2_rtype(io_iss_uop_lrs2_rtype),
        .io_iss_uop_br_mask(io_iss_uop_br_mask), .io_iss_uop_payload(io_iss_uop_payload)
`ifdef ISSUE_QUEUE_COUNT_EN
        , .io_count(io_count)
`endif
    );

    typedef struct {
        logic [6:0]    uopc, prs1, prs2;
        logic [1:0]    rt1, rt2;
        bit            p1, p2;
        logic [15:0]   brm;
        logic [PW-1:0] pay;
    } ent_t;

    typedef struct {
        int   cyc;
        ent_t e;
    } exp_t;

    ent_t mq[$];       // model queue, oldest first
    ent_t oreg;
    bit   oreg_v = 1'b0;
    exp_t sbq[$];      // expected issues, stamped with their cycle
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   running = 1'b0;

    function automatic bit woken(input logic [6:0] p);
        for (int k = 0; k < WP; k++)
            if (io_wakeup_valid[k] && io_wakeup_pdst[7*k +: 7] == p) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: one cycle of queue behaviour, evaluated with this
    // cycle's inputs; pushes the expected issue for the current cycle.
    task automatic model_step();
        ent_t nq[$];
        ent_t e;
        exp_t x;
        int   sel;
        bit   rdy;
        sel = -1;
        rdy = (mq.size() < N);
        checks++;
        if (io_enq_ready !== rdy) begin
            errors++;
            $display("FAIL enq_ready cyc=%0d got=%b exp=%b", cyc, io_enq_ready, rdy);
        end
`ifdef ISSUE_QUEUE_COUNT_EN
        checks++;
        if (io_count !== 4'(mq.size())) begin
            errors++;
            $display("FAIL count cyc=%0d got=%0d exp=%0d", cyc, io_count, mq.size());
        end
`endif
        if (oreg_v && (oreg.brm & io_br_mispredict_mask) == 16'h0 && !io_flush) begin
            x.cyc = cyc;
            x.e   = oreg;
            sbq.push_back(x);
        end
        for (int i = 0; i < mq.size(); i++)
            if (sel < 0 && mq[i].p1 && mq[i].p2 && (mq[i].brm & io_br_mispredict_mask) == 16'h0)
                sel = i;
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (io_flush || (e.brm & io_br_mispredict_mask) != 16'h0 || i == sel) continue;
            if (e.rt1 == 2'h0 && woken(e.prs1)) e.p1 = 1'b1;
            if (e.rt2 == 2'h0 && woken(e.prs2)) e.p2 = 1'b1;
            e.brm = e.brm & ~io_br_resolve_mask;
            nq.push_back(e);
        end
        if (io_enq_valid && rdy && !io_flush && (io_enq_uop_br_mask & io_br_mispredict_mask) == 16'h0) begin
            e.uopc = io_enq_uop_uopc;
            e.prs1 = io_enq_uop_prs1;
            e.prs2 = io_enq_uop_prs2;
            e.rt1  = io_enq_uop_lrs1_rtype;
            e.rt2  = io_enq_uop_lrs2_rtype;
            e.p1   = (e.rt1 != 2'h0) || !io_enq_prs1_busy || woken(e.prs1);
            e.p2   = (e.rt2 != 2'h0) || !io_enq_prs2_busy || woken(e.prs2);
            e.brm  = io_enq_uop_br_mask & ~io_br_resolve_mask;
            e.pay  = io_enq_uop_payload;
            nq.push_back(e);
        end
        if (sel >= 0 && !io_flush) begin
            oreg     = mq[sel];
            oreg.brm = oreg.brm & ~io_br_resolve_mask;
            oreg_v   = 1'b1;
        end else begin
            oreg_v = 1'b0;
        end
        mq = nq;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            #2;
            if (running) begin
                checks++;
                if (io_iss_valid === 1'b1) begin
                    if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
                        errors++;
                        $display("FAIL iss_unexpected cyc=%0d got valid=1 uopc=%h exp no issue", cyc, io_iss_uop_uopc);
                    end else begin
                        x = sbq.pop_front();
                        if (io_iss_uop_uopc !== x.e.uopc || io_iss_uop_prs1 !== x.e.prs1 ||
                            io_iss_uop_prs2 !== x.e.prs2 || io_iss_uop_lrs1_rtype !== x.e.rt1 ||
                            io_iss_uop_lrs2_rtype !== x.e.rt2 || io_iss_uop_br_mask !== x.e.brm ||
                            io_iss_uop_payload !== x.e.pay) begin
                            errors++;
                            $display("FAIL iss_fields cyc=%0d got uopc=%h prs=%h/%h brm=%h pay=%h exp uopc=%h prs=%h/%h brm=%h pay=%h",
                                     cyc, io_iss_uop_uopc, io_iss_uop_prs1, io_iss_uop_prs2, io_iss_uop_br_mask,
                                     io_iss_uop_payload, x.e.uopc, x.e.prs1, x.e.prs2, x.e.brm, x.e.pay);
                        end
                    end
                end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                    x = sbq.pop_front();
                    errors++;
                    $display("FAIL iss_missing cyc=%0d got valid=%b exp uopc=%h", cyc, io_iss_valid, x.e.uopc);
                end
            end
        end
    end

    task automatic set_idle();
        io_enq_valid          = 1'b0;
        io_enq_uop_uopc       = '0;
        io_enq_uop_prs1       = '0;
        io_enq_uop_prs2       = '0;
        io_enq_uop_lrs1_rtype = '0;
        io_enq_uop_lrs2_rtype = '0;
        io_enq_prs1_busy      = 1'b0;
        io_enq_prs2_busy      = 1'b0;
        io_enq_uop_br_mask    = '0;
        io_enq_uop_payload    = '0;
        io_wakeup_valid       = '0;
        io_wakeup_pdst        = '0;
        io_br_resolve_mask    = '0;
        io_br_mispredict_mask = '0;
        io_flush              = 1'b0;
    endtask

    task automatic begin_cycle();
        @(negedge clock);
        cyc++;
        set_idle();
    endtask

    task automatic end_cycle();
        #1;
        model_step();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    task automatic set_enq(input logic [6:0] uopc, input logic [6:0] p1, input logic [6:0] p2,
                           input bit b1, input bit b2, input logic [15:0] brm);
        io_enq_valid       = 1'b1;
        io_enq_uop_uopc    = uopc;
        io_enq_uop_prs1    = p1;
        io_enq_uop_prs2    = p2;
        io_enq_prs1_busy   = b1;
        io_enq_prs2_busy   = b2;
        io_enq_uop_br_mask = brm;
        io_enq_uop_payload = {$urandom, $urandom};
    endtask

    task automatic set_wake(input int port, input logic [6:0] p);
        io_wakeup_valid[port]        = 1'b1;
        io_wakeup_pdst[7*port +: 7]  = p;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (io_iss_valid !== 1'b0 || io_iss_uop_uopc !== 7'h0 || io_iss_uop_prs1 !== 7'h0 ||
            io_iss_uop_prs2 !== 7'h0 || io_iss_uop_br_mask !== 16'h0 || io_iss_uop_payload !== '0 ||
            io_iss_uop_lrs1_rtype !== 2'h0 || io_iss_uop_lrs2_rtype !== 2'h0 || io_enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s got valid=%b uopc=%h brm=%h ready=%b exp valid=0 fields=0 ready=1",
                     tag, io_iss_valid, io_iss_uop_uopc, io_iss_uop_br_mask, io_enq_ready);
        end
    endtask

    // Asynchronous reset asserted between clock edges, after the monitor
    task automatic mid_reset();
        #2;
        running = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        set_idle();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        mq.delete();
        sbq.delete();
        oreg_v  = 1'b0;
        running = 1'b1;
    endtask

    initial begin
        set_idle();
        reset_n = 1'b0;
        #4;
        check_reset_outputs("reset_state");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        running = 1'b1;

        // Basic 2-cycle latency
        begin_cycle(); set_enq(7'h19, 7'd5, 7'd6, 1'b0, 1'b0, 16'h0); end_cycle();
        idle_cycles(2);
        #1;
        checks++;
        if (io_iss_valid !== 1'b1 || io_iss_uop_prs1 !== 7'd5 || io_iss_uop_prs2 !== 7'd6) begin
            errors++;
            $display("FAIL t1_latency got valid=%b prs1=%0d prs2=%0d exp valid=1 prs1=5 prs2=6",
                     io_iss_valid, io_iss_uop_prs1, io_iss_uop_prs2);
        end
        idle_cycles(2);

        // Younger ready uop bypasses older waiting one; wakeup releases the older
        begin_cycle(); set_enq(7'h0A, 7'd9, 7'd1, 1'b1, 1'b0, 16'h0); end_cycle();
        begin_cycle(); set_enq(7'h0B, 7'd2, 7'd1, 1'b0, 1'b0, 16'h0); end_cycle();
        idle_cycles(2);
        begin_cycle(); set_wake(0, 7'd9); end_cycle();
        idle_cycles(3);

        // Fill to capacity, attempt an extra enqueue, then drain in order
        for (int i = 0; i < N; i++) begin
            begin_cycle(); set_enq(7'(7'h20 + i), 7'd3, 7'd4, 1'b1, 1'b0, 16'h0); end_cycle();
        end
        begin_cycle(); set_enq(7'h2F, 7'd1, 7'd1, 1'b0, 1'b0, 16'h0); end_cycle();
        #1;
        checks++;
        if (io_enq_ready !== 1'b0) begin
            errors++;
            $display("FAIL t3_full got ready=%b exp ready=0", io_enq_ready);
        end
        begin_cycle(); set_wake(1, 7'd3); end_cycle();
        idle_cycles(N + 3);

        // Mispredict kills one of two waiting entries; resolve clears the survivor's mask
        begin_cycle(); set_enq(7'h31, 7'd10, 7'd1, 1'b1, 1'b0, 16'h0001); end_cycle();
        begin_cycle(); set_enq(7'h32, 7'd11, 7'd1, 1'b1, 1'b0, 16'h0002); end_cycle();
        idle_cycles(1);
        begin_cycle(); io_br_mispredict_mask = 16'h0001; end_cycle();
        begin_cycle(); io_br_resolve_mask = 16'h0002; end_cycle();
        begin_cycle(); set_wake(0, 7'd11); set_wake(1, 7'd10); end_cycle();
        idle_cycles(3);

        // Same-cycle wakeup on enqueue
        begin_cycle(); set_enq(7'h40, 7'd12, 7'd13, 1'b1, 1'b0, 16'h0); set_wake(1, 7'd12); end_cycle();
        idle_cycles(3);

        // Flush with three waiting entries and a held output
        for (int i = 0; i < 3; i++) begin
            begin_cycle(); set_enq(7'(7'h50 + i), 7'd20, 7'd21, 1'b1, 1'b0, 16'h0); end_cycle();
        end
        begin_cycle(); set_enq(7'h5F, 7'd1, 7'd2, 1'b0, 1'b0, 16'h0); end_cycle();
        idle_cycles(1);
        begin_cycle(); io_flush = 1'b1; set_enq(7'h60, 7'd1, 7'd2, 1'b0, 1'b0, 16'h0); end_cycle();
        #1;
        checks++;
        if (io_iss_valid !== 1'b0) begin
            errors++;
            $display("FAIL t6_flush_gate got valid=%b exp valid=0", io_iss_valid);
        end
        begin_cycle(); set_wake(0, 7'd20); end_cycle();
        idle_cycles(3);

        // Random traffic with one asynchronous reset part-way through
        for (int n = 0; n < 3000; n++) begin
            begin_cycle();
            if ($urandom_range(0, 9) < 6) begin
                set_enq(7'($urandom_range(0, 127)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom_range(0, 15)));
                if ($urandom_range(0, 5) == 0) io_enq_uop_lrs1_rtype = 2'($urandom_range(1, 3));
                if ($urandom_range(0, 5) == 0) io_enq_uop_lrs2_rtype = 2'($urandom_range(1, 3));
            end
            for (int k = 0; k < WP; k++)
                if ($urandom_range(0, 9) < 3) set_wake(k, 7'($urandom_range(0, 7)));
            if ($urandom_range(0, 19) == 0) io_br_mispredict_mask = 16'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) io_br_resolve_mask = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) io_flush = 1'b1;
            end_cycle();
            if (n == 1500) mid_reset();
        end

        // Drain and confirm every expected issue was observed
        begin_cycle();
        for (int k = 0; k < WP; k++) set_wake(k, 7'(k));
        end_cycle();
        idle_cycles(12);
        #3;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d exp pending=0", sbq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
